// File: rtl/config_pkg.sv
// Project-wide configuration shared by the UART datapath blocks.
package config_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/uart_arb_pkg.sv
// Types and constants for the UART arbiter: FSM state encoding and header tag.
package uart_arb_pkg;
    import config_pkg::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam word_t UART_ARB_HDR = 32'hA5A5_0000;
endpackage

// File: rtl/uart_arb_rr_pick.sv
// Round-robin pick: first set request after 'last', wrapping modulo NUM_REQ.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int GW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last,
    output logic               valid,
    output logic [GW-1:0]      idx
);
    logic [31:0] cand;

    always_comb begin
        valid = |req;
        idx   = '0;
        cand  = '0;
        // Walk from farthest to nearest so the nearest set bit overwrites last.
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (32'(last) + 32'(k)) % 32'(NUM_REQ);
            if (req[cand[GW-1:0]]) begin
                idx = cand[GW-1:0];
            end
        end
    end
endmodule

// File: rtl/uart_arb.sv
// Round-robin arbiter multiplexing NUM_REQ fifos onto one UART in bursts.
// Optional per-grant header word enabled by defining UART_ARB_TAG_EN.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin
// HDR   | present header tag for the new owner (UART_ARB_TAG_EN only)
// BURST | forward owner's fifo words until BURST_LEN sent or fifo empties
module uart_arb
    import config_pkg::*;
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 2,
    parameter  int BURST_LEN = 4,
    localparam int GW        = $clog2(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0][WORD_W-1:0] data_i,
    output logic [NUM_REQ-1:0]             pop_o,
    output logic [WORD_W-1:0]              d_out_o,
    output logic                           rts_o,
    input  logic                           next_i,
    output logic [GW-1:0]                  grant_o,
    output logic                           busy_o
);
    localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [7:0]    cnt;
    logic          pick_valid;
    logic [GW-1:0] pick_idx;
    logic          xfer;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req_i),
        .last  (last_grant),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Outputs are forced quiet while reset is asserted so an aborted burst never pops.
    always_comb begin
        pop_o   = '0;
        rts_o   = 1'b0;
        d_out_o = '0;
        if (!reset_i) begin
            case (state)
                BURST: begin
                    rts_o           = req_i[grant_o];
                    d_out_o         = data_i[grant_o];
                    pop_o[grant_o]  = next_i & req_i[grant_o];
                end
`ifdef UART_ARB_TAG_EN
                HDR: begin
                    rts_o   = 1'b1;
                    d_out_o = UART_ARB_HDR | WORD_W'(grant_o);
                end
`endif
                default: ;
            endcase
        end
        busy_o = !reset_i && (state != IDLE);
        xfer   = rts_o & next_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            grant_o    <= '0;
            cnt        <= '0;
            last_grant <= GW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_o <= pick_idx;
                        cnt     <= '0;
`ifdef UART_ARB_TAG_EN
                        state   <= HDR;
`else
                        state   <= BURST;
`endif
                    end
                end
`ifdef UART_ARB_TAG_EN
                HDR: begin
                    if (xfer) begin
                        state <= BURST;
                    end
                end
`endif
                BURST: begin
                    if ((xfer && cnt == LAST_CNT) || !req_i[grant_o]) begin
                        state      <= IDLE;
                        last_grant <= grant_o;
                    end else if (xfer) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_arb.sv
// Self-checking bench for uart_arb: fifo queues feed the arbiter, a word-level
// reference model predicts every output each cycle, plus directed scenarios.
module tb_uart_arb;
    import config_pkg::*;

    localparam int NUM_REQ   = 2;
    localparam int BURST_LEN = 4;
    localparam int GW        = $clog2(NUM_REQ);
`ifdef UART_ARB_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic                           clk_i = 1'b0;
    logic                           reset_i;
    logic [NUM_REQ-1:0]             req_i;
    logic [NUM_REQ-1:0][WORD_W-1:0] data_i;
    logic [NUM_REQ-1:0]             pop_o;
    logic [WORD_W-1:0]              d_out_o;
    logic                           rts_o;
    logic                           next_i;
    logic [GW-1:0]                  grant_o;
    logic                           busy_o;

    uart_arb #(.NUM_REQ(NUM_REQ), .BURST_LEN(BURST_LEN)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .req_i   (req_i),
        .data_i  (data_i),
        .pop_o   (pop_o),
        .d_out_o (d_out_o),
        .rts_o   (rts_o),
        .next_i  (next_i),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    logic [WORD_W-1:0] fq [NUM_REQ][$];
    bit                rst_drv;
    int                next_mode;

    // Reference model: owner (-1 = none), words sent this grant, last finished owner.
    int own, sent, last, exp_grant;
    bit hdr;

    int                ag[$];
    int                ab[$];
    logic [WORD_W-1:0] afw[$];
    bit                first_pend, prev_busy;
    logic              last_rts;
    logic [NUM_REQ-1:0] obs_pop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_q(input string nm, input int act[$], input int exp[$]);
        chk({nm, "_len"}, 32'(act.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            chk(nm, 32'(act[i]), 32'(exp[i]));
    endtask

    task automatic observe();
        logic [NUM_REQ-1:0] ep;
        logic [31:0]        ed;
        bit                 er, eb;
        eb = !reset_i && own >= 0;
        er = eb && (hdr || (own >= 0 ? req_i[own] : 1'b0));
        ed = '0;
        ep = '0;
        if (eb) begin
            if (hdr) ed = 32'hA5A5_0000 | 32'(own);
            else begin
                ed = data_i[own];
                if (req_i[own] && next_i) ep[own] = 1'b1;
            end
        end
        chk("busy", 32'(busy_o), 32'(eb));
        chk("rts", 32'(rts_o), 32'(er));
        chk("pop", 32'(pop_o), 32'(ep));
        chk("grant", 32'(grant_o), 32'(exp_grant));
        if (er) chk("d_out", d_out_o, ed);
        else    chk("d_out_idle", d_out_o, 32'h0);

        if (busy_o && !reset_i && !prev_busy) begin
            ag.push_back(int'(grant_o));
            ab.push_back(0);
            afw.push_back('0);
            first_pend = 1'b1;
        end
        if (ab.size() > 0 && pop_o != '0) ab[ab.size()-1]++;
        if (first_pend && rts_o && next_i && !reset_i) begin
            afw[afw.size()-1] = d_out_o;
            first_pend = 1'b0;
        end
        prev_busy = busy_o && !reset_i;
        last_rts  = rts_o;
        obs_pop   = pop_o;
    endtask

    task automatic model_step();
        if (reset_i) begin
            own = -1; last = NUM_REQ - 1; exp_grant = 0; hdr = 1'b0; sent = 0;
        end else if (own < 0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int c;
                c = (last + k) % NUM_REQ;
                if (req_i[c] && own < 0) own = c;
            end
            if (own >= 0) begin
                sent = 0; hdr = TAG; exp_grant = own;
            end
        end else if (hdr) begin
            if (next_i) hdr = 1'b0;
        end else begin
            if (req_i[own] && next_i) sent++;
            if (sent == BURST_LEN || !req_i[own]) begin
                last = own; own = -1;
            end
        end
    endtask

    task automatic cycle();
        logic [WORD_W-1:0] dummy;
        @(negedge clk_i);
        reset_i = rst_drv;
        next_i  = (next_mode == 2) ? 1'($urandom_range(0, 1)) : (next_mode == 1);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_i[i]  = fq[i].size() != 0;
            data_i[i] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
        #1;
        observe();
        @(posedge clk_i);
        for (int i = 0; i < NUM_REQ; i++)
            if (obs_pop[i] && fq[i].size() > 0) dummy = fq[i].pop_front();
        model_step();
    endtask

    task automatic clear_track();
        ag.delete(); ab.delete(); afw.delete(); first_pend = 1'b0;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NUM_REQ; i++) fq[i].delete();
        rst_drv = 1'b1;
        repeat (2) cycle();
        rst_drv = 1'b0;
        clear_track();
    endtask

    task automatic load(input int r, input int n);
        for (int k = 0; k < n; k++) fq[r].push_back(32'((r + 1) << 16) | 32'(k));
    endtask

    initial begin
        int guard, r;
        reset_i = 1'b1; next_i = 1'b0; req_i = '0; data_i = '0;
        rst_drv = 1'b1; next_mode = 0;
        own = -1; last = NUM_REQ - 1; exp_grant = 0; hdr = 1'b0; sent = 0;
        prev_busy = 1'b0; first_pend = 1'b0; last_rts = 1'b0; obs_pop = '0;

        // reset state
        do_reset();
        next_mode = 0;
        cycle();
        chk("rst_rts", 32'(rts_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_dout", d_out_o, 32'h0);
        chk("rst_grant", 32'(grant_o), 32'h0);

        // single requester, 6 words, burst of 4 then 2
        do_reset(); load(0, 6); next_mode = 1;
        repeat (20) cycle();
        chk_q("single_grants", ag, '{0, 0});
        chk_q("single_bursts", ab, '{4, 2});

        // fairness with both requesting continuously
        do_reset(); load(0, 8); load(1, 8); next_mode = 1;
        repeat (30) cycle();
        chk_q("fair_grants", ag, '{0, 1, 0, 1});
        chk_q("fair_bursts", ab, '{4, 4, 4, 4});
        if (afw.size() > 1)
            chk("fair_first_word_req1", afw[1], TAG ? 32'hA5A5_0001 : 32'h0002_0000);
        else
            chk("fair_first_word_present", 32'(afw.size()), 32'd2);

        // early empty hands over to req1
        do_reset(); load(0, 2); load(1, 3); next_mode = 1;
        repeat (16) cycle();
        chk_q("early_grants", ag, '{0, 1});
        chk_q("early_bursts", ab, '{2, 3});

        // stray next_i in IDLE, then a fresh burst must still count from zero
        do_reset(); next_mode = 1;
        repeat (6) cycle();
        chk("stray_no_grant", 32'(ag.size()), 32'h0);
        load(0, 5);
        repeat (16) cycle();
        chk_q("stray_grants", ag, '{0, 0});
        chk_q("stray_bursts", ab, '{4, 1});

        // reset in the middle of a burst
        do_reset(); load(0, 8); load(1, 4); next_mode = 1;
        guard = 0;
        while (!(ab.size() > 0 && ab[0] >= 2) && guard < 20) begin
            cycle();
            guard++;
        end
        chk("mid_reached_two", 32'(guard < 20), 32'h1);
        rst_drv = 1'b1;
        cycle();
        chk("mid_rts_in_reset", 32'(last_rts), 32'h0);
        rst_drv = 1'b0;
        clear_track();
        cycle();
        chk("mid_rts_after", 32'(last_rts), 32'h0);
        repeat (8) cycle();
        chk("mid_regrant", 32'(ag.size() > 0 ? ag[0] : -1), 32'h0);

        // randomized traffic, next_i and occasional reset
        do_reset(); next_mode = 2;
        for (int c = 0; c < 1500; c++) begin
            rst_drv = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, NUM_REQ - 1);
                if (fq[r].size() < 6) fq[r].push_back($urandom);
            end
            cycle();
        end
        rst_drv = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_arb.md
UART_ARB -- requirements
Module: uart_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters (fifo instances); legal range 2..8.
REQ-002 Parameter BURST_LEN, default 4, max words one requester sends per grant; legal range 1..255.
REQ-003 clk_i  input  1  single system clock; all state updates on rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 req_i  input  NUM_REQ  per-requester "word available" (fifo have_next).
REQ-006 data_i  input  NUM_REQ x word  per-requester head-of-fifo word.
REQ-007 pop_o  output  NUM_REQ  per-requester consume strobe (fifo next).
REQ-008 d_out_o  output  word  word presented to uart d_in.
REQ-009 rts_o  output  1  word valid toward uart (uart rts).
REQ-010 next_i  input  1  uart consume pulse (uart next).
REQ-011 grant_o  output  $clog2(NUM_REQ)  index of current owner.
REQ-012 busy_o  output  1  high when state is not IDLE.

Function
REQ-013 FSM states: IDLE, HDR (only with UART_ARB_TAG_EN), BURST.
REQ-014 IDLE: rts_o=0, pop_o=0; if any req_i bit set, register winner into grant_o; go to HDR or BURST next cycle.
REQ-015 Winner: round-robin; search starts at last_grant+1, wraps modulo NUM_REQ; last_grant ends as the index of the most recent finished burst.
REQ-016 Transfer: a word is transferred in any cycle with rts_o=1 and next_i=1.
REQ-017 BURST: rts_o = req_i[grant_o]; d_out_o = data_i[grant_o]; pop_o[grant_o] = next_i & rts_o, same cycle (combinational); all other pop_o bits 0.
REQ-018 BURST word counter: 8-bit, cleared on grant, incremented per transfer.
REQ-019 Burst end: transfer with counter = BURST_LEN-1, or req_i[grant_o]=0 with no transfer that cycle; either -> IDLE next cycle, last_grant <= grant_o.
REQ-020 Latency: req_i rising in IDLE -> rts_o high 1 cycle later (2 with header).
REQ-021 next_i while rts_o=0 is ignored: no pop, no count change.
REQ-022 Requests by non-owners during BURST are not serviced until the return to IDLE; at most one pop_o bit high per cycle.
REQ-023 data_i[grant_o] must stay stable while rts_o=1 and next_i=0.

Reset
REQ-024 reset_i=1: state IDLE, grant_o=0, counter=0, last_grant=NUM_REQ-1 (so requester 0 wins first).
REQ-025 Outputs during and after reset: rts_o=0, pop_o=0, busy_o=0, d_out_o=0.
REQ-026 Reset mid-burst aborts the burst in the same edge; no pop_o is issued in the reset cycle.

Configuration
REQ-027 Macro UART_ARB_TAG_EN defined: each grant first enters HDR.
REQ-028 In HDR: rts_o=1, d_out_o = 32'hA5A5_0000 | grant_o, pop_o=0; transfer -> BURST.
REQ-029 Header words do not count toward BURST_LEN.
REQ-030 UART_ARB_TAG_EN undefined: HDR state and header logic are absent; IDLE goes directly to BURST.

Structure
REQ-031 Shared package holds the FSM state enum type and the header constant UART_ARB_HDR = 32'hA5A5_0000; word comes from config_pkg.
REQ-032 One combinational sub-module, rr_pick, takes (req, last) and returns (valid, idx); no other sub-modules.

Verification
REQ-033 Single requester: req_i=01, 6 words queued, BURST_LEN=4 -> 4 pops to req0, IDLE, re-grant req0, 2 pops.
REQ-034 Fairness: req_i=11 continuously, BURST_LEN=4 -> grant sequence 0,1,0,1; 4 words each; pop_o never 11.
REQ-035 Early empty: req0 has 2 words -> 2 transfers, req_i[0] drops, IDLE next cycle, req1 granted.
REQ-036 Stray next_i: next_i pulses in IDLE -> pop_o stays 00, counter stays 0.
REQ-037 Reset mid-burst after 2 transfers -> rts_o=0 next cycle; next grant goes to req0.
REQ-038 With UART_ARB_TAG_EN, req1 granted -> first word 32'hA5A5_0001, then req1 data; pop_o[1] low during header.
